// File: rtl/spi_display_receiver.sv
// SPI receiver for display controllers: deserialises MSB-first bytes tagged data/command
// and hands them to a valid/ready consumer. Define SPI_RX_BYTE_COUNT_EN to enable the per-frame byte counter.
module spi_display_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    input  logic        dc,
    output logic [7:0]  rxData,
    output logic        rxIsCmd,
    output logic        rxValid,
    input  logic        rxReady,
    output logic        overrun,
    output logic        frameError,
    output logic [15:0] byteCount
);

    typedef enum logic {
        IDLE,
        SHIFT
    } stateT;

    stateT state;

    logic [SYNC_STAGES-1:0] sclkSync;
    logic [SYNC_STAGES-1:0] mosiSync;
    logic [SYNC_STAGES-1:0] csSync;
    logic [SYNC_STAGES-1:0] dcSync;

    logic       sclkS;
    logic       mosiS;
    logic       csS;
    logic       dcS;
    logic       sclkPrev;
    logic       sclkRise;
    logic       commit;
    logic       consume;
    logic [2:0] bitCnt;
    // Only the first seven bits are stored; the eighth is taken straight from mosiS at commit.
    logic [6:0] shiftReg;
    logic [7:0] newByte;

    // Reset values match an idle bus so no false edges appear after reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclkSync <= '0;
            mosiSync <= '0;
            csSync   <= '1;
            dcSync   <= '1;
            sclkPrev <= 1'b0;
        end else begin
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], sclk};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
            csSync   <= {csSync[SYNC_STAGES-2:0], cs};
            dcSync   <= {dcSync[SYNC_STAGES-2:0], dc};
            sclkPrev <= sclkS;
        end
    end

    assign sclkS    = sclkSync[SYNC_STAGES-1];
    assign mosiS    = mosiSync[SYNC_STAGES-1];
    assign csS      = csSync[SYNC_STAGES-1];
    assign dcS      = dcSync[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev;
    assign newByte  = {shiftReg, mosiS};
    assign commit   = (state == SHIFT) && !csS && sclkRise && (bitCnt == 3'd7);
    assign consume  = rxValid && rxReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shiftReg   <= '0;
            bitCnt     <= '0;
            frameError <= 1'b0;
        end else begin
            frameError <= 1'b0;
            case (state)
                IDLE: begin
                    if (!csS) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (csS) begin
                        state      <= IDLE;
                        shiftReg   <= '0;
                        bitCnt     <= '0;
                        frameError <= (bitCnt != 3'd0);
                    end else if (sclkRise) begin
                        shiftReg <= newByte[6:0];
                        bitCnt   <= bitCnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A commit into a still-held byte is dropped; a same-cycle consume frees the slot first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxData  <= 8'h00;
            rxIsCmd <= 1'b0;
            rxValid <= 1'b0;
            overrun <= 1'b0;
        end else if (commit) begin
            if (rxValid && !rxReady) begin
                overrun <= 1'b1;
            end else begin
                rxData  <= newByte;
                rxIsCmd <= ~dcS;
                rxValid <= 1'b1;
            end
        end else if (consume) begin
            rxValid <= 1'b0;
        end
    end

`ifdef SPI_RX_BYTE_COUNT_EN
    logic        csPrev;
    logic [15:0] byteCountReg;

    // Counts every completed byte in the frame, dropped ones included.
    always_ff @(posedge clk) begin
        if (reset) begin
            csPrev       <= 1'b1;
            byteCountReg <= '0;
        end else begin
            csPrev <= csS;
            if (csPrev && !csS) begin
                byteCountReg <= '0;
            end else if (commit) begin
                byteCountReg <= byteCountReg + 16'd1;
            end
        end
    end

    assign byteCount = byteCountReg;
`else
    assign byteCount = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_display_receiver.sv
// Scoreboard bench for spi_display_receiver: expected bytes are queued as they are sent
// and compared when the consumer accepts them.
module tb_spi_display_receiver;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        dc;
    logic [7:0]  rxData;
    logic        rxIsCmd;
    logic        rxValid;
    logic        rxReady;
    logic        overrun;
    logic        frameError;
    logic [15:0] byteCount;

    int total = 0;
    int bad = 0;
    int feCycles = 0;
    int validCycles = 0;
    logic [8:0] sb[$];

    spi_display_receiver #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs         (cs),
        .dc         (dc),
        .rxData     (rxData),
        .rxIsCmd    (rxIsCmd),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .overrun    (overrun),
        .frameError (frameError),
        .byteCount  (byteCount)
    );

    always #5 clk = ~clk;

    // Samples between edges; a byte is popped whenever the DUT will hand it over.
    task automatic run_monitor();
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (frameError === 1'b1) feCycles++;
            if (rxValid === 1'b1) validCycles++;
            if (rxValid === 1'b1 && rxReady === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_byte: got isCmd=%0b data=%02h, required no byte", rxIsCmd, rxData);
                end else begin
                    exp = sb.pop_front();
                    if ({rxIsCmd, rxData} !== exp) begin
                        bad++;
                        $display("[TB] FAIL byte: got isCmd=%0b data=%02h, required isCmd=%0b data=%02h",
                                 rxIsCmd, rxData, exp[8], exp[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic csLow();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csHigh();
        @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Shifts nbits of b MSB first; readyAtCommit pulses rxReady exactly on the commit cycle.
    task automatic applyStimulus(input logic [7:0] b, input logic dcBit, input int nbits, input bit readyAtCommit);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi = b[7-i];
            dc   = dcBit;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            if (readyAtCommit && i == nbits - 1) begin
                repeat (SYNC) @(negedge clk);
                rxReady = 1'b1;
                @(negedge clk);
                rxReady = 1'b0;
            end else begin
                repeat (3) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b1; rxReady = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rxData !== 8'h00) begin bad++; $display("[TB] FAIL reset_rxData: got %02h, required 00", rxData); end
        total++; if (rxIsCmd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rxIsCmd: got %0b, required 0", rxIsCmd); end
        total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rxValid: got %0b, required 0", rxValid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %0b, required 0", overrun); end
        total++; if (frameError !== 1'b0) begin bad++; $display("[TB] FAIL reset_frameError: got %0b, required 0", frameError); end
        total++; if (byteCount !== 16'h0000) begin bad++; $display("[TB] FAIL reset_byteCount: got %04h, required 0000", byteCount); end
    endtask

    task automatic test_command();
        int v0;
        rxReady = 1'b1;
        v0 = validCycles;
        csLow();
        sb.push_back({1'b1, 8'h3C});
        applyStimulus(8'h3C, 1'b0, 8, 1'b0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL cmd_delivered: got pending=%0d, required 0", sb.size()); end
        csHigh();
        total++; if (validCycles - v0 != 1) begin bad++; $display("[TB] FAIL cmd_valid_width: got %0d cycles, required 1", validCycles - v0); end
        total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL cmd_valid_after: got %0b, required 0", rxValid); end
    endtask

    task automatic test_overrun();
        logic [15:0] expCount;
`ifdef SPI_RX_BYTE_COUNT_EN
        expCount = 16'd2;
`else
        expCount = 16'd0;
`endif
        rxReady = 1'b0;
        csLow();
        sb.push_back({1'b0, 8'hAA});
        applyStimulus(8'hAA, 1'b1, 8, 1'b0);
        applyStimulus(8'h55, 1'b1, 8, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (rxData !== 8'hAA) begin bad++; $display("[TB] FAIL ovr_rxData: got %02h, required AA", rxData); end
        total++; if (rxIsCmd !== 1'b0) begin bad++; $display("[TB] FAIL ovr_rxIsCmd: got %0b, required 0", rxIsCmd); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag: got %0b, required 1", overrun); end
        total++; if (byteCount !== expCount) begin bad++; $display("[TB] FAIL ovr_byteCount: got %0d, required %0d", byteCount, expCount); end
        csHigh();
        total++; if (rxValid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_hold_over_cs: got %0b, required 1", rxValid); end
        @(negedge clk);
        rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL ovr_delivered: got pending=%0d, required 0", sb.size()); end
        total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_consumed: got %0b, required 0", rxValid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky: got %0b, required 1", overrun); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_reset_clear: got %0b, required 0", overrun); end
    endtask

    task automatic test_frame_error();
        int fe0;
        int v0;
        rxReady = 1'b1;
        fe0 = feCycles;
        v0 = validCycles;
        csLow();
        applyStimulus(8'hFF, 1'b1, 5, 1'b0);
        csHigh();
        total++; if (feCycles - fe0 != 1) begin bad++; $display("[TB] FAIL fe_pulse: got %0d cycles, required 1", feCycles - fe0); end
        total++; if (validCycles - v0 != 0) begin bad++; $display("[TB] FAIL fe_no_valid: got %0d cycles, required 0", validCycles - v0); end
        csLow();
        sb.push_back({1'b0, 8'h81});
        applyStimulus(8'h81, 1'b1, 8, 1'b0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL fe_recover: got pending=%0d, required 0", sb.size()); end
        csHigh();
        total++; if (feCycles - fe0 != 1) begin bad++; $display("[TB] FAIL fe_clean_close: got %0d cycles, required 1", feCycles - fe0); end
    endtask

    task automatic test_back_to_back();
        rxReady = 1'b0;
        csLow();
        sb.push_back({1'b0, 8'h12});
        sb.push_back({1'b0, 8'h34});
        applyStimulus(8'h12, 1'b1, 8, 1'b0);
        repeat (3) @(negedge clk);
        total++; if (rxData !== 8'h12) begin bad++; $display("[TB] FAIL b2b_first: got %02h, required 12", rxData); end
        applyStimulus(8'h34, 1'b1, 8, 1'b1);
        total++; if (rxData !== 8'h34) begin bad++; $display("[TB] FAIL b2b_rxData: got %02h, required 34", rxData); end
        total++; if (rxValid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_rxValid: got %0b, required 1", rxValid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun: got %0b, required 0", overrun); end
        total++; if (sb.size() != 1) begin bad++; $display("[TB] FAIL b2b_first_taken: got pending=%0d, required 1", sb.size()); end
        @(negedge clk);
        rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL b2b_second_taken: got pending=%0d, required 0", sb.size()); end
        csHigh();
    endtask

    task automatic test_reset_mid_byte();
        int fe0;
        rxReady = 1'b1;
        fe0 = feCycles;
        csLow();
        applyStimulus(8'hFF, 1'b1, 4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (rxValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid: got %0b, required 0", rxValid); end
        csHigh();
        csLow();
        sb.push_back({1'b0, 8'hA5});
        applyStimulus(8'hA5, 1'b1, 8, 1'b0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL rst_mid_byte: got pending=%0d, required 0", sb.size()); end
        csHigh();
        total++; if (feCycles - fe0 != 0) begin bad++; $display("[TB] FAIL rst_mid_no_fe: got %0d cycles, required 0", feCycles - fe0); end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_command();
        test_overrun();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_byte();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_display_receiver.md
SPI_DISPLAY_RECEIVER -- requirements
Module: spi_display_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk/mosi/cs/dc (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port sclk  input  1  serial clock from host, asynchronous to clk.
REQ-005 SHALL have port mosi  input  1  serial data from host, MSB first, valid on sclk rising edge.
REQ-006 SHALL have port cs  input  1  chip select, active low; high frames the bus idle.
REQ-007 SHALL have port dc  input  1  data/command select: 1 = data byte, 0 = command byte.
REQ-008 SHALL have port rxData  output  8  last completed byte.
REQ-009 SHALL have port rxIsCmd  output  1  1 when rxData was received with dc = 0.
REQ-010 SHALL have port rxValid  output  1  rxData/rxIsCmd hold an unconsumed byte.
REQ-011 SHALL have port rxReady  input  1  consumer accepts byte when rxValid && rxReady at clk edge.
REQ-012 SHALL have port overrun  output  1  sticky: a completed byte was dropped.
REQ-013 SHALL have port frameError  output  1  one-cycle pulse: cs rose with a partial byte.
REQ-014 SHALL have port byteCount  output  16  completed bytes since last cs falling edge (see Configuration).

Function
REQ-015 SHALL pass sclk, mosi, cs, dc each through SYNC_STAGES flops; all logic below uses synchronized copies (sclkS, mosiS, csS, dcS).
REQ-016 SHALL detect sclkRise as sclkS = 1 with previous sclkS = 0; sclk falling edges SHALL be ignored.
REQ-017 SHALL implement states IDLE and SHIFT; IDLE -> SHIFT when csS = 0; SHIFT -> IDLE when csS = 1.
REQ-018 In SHIFT, each sclkRise SHALL shift mosiS into an 8-bit shift register LSB end and increment a 3-bit bit counter.
REQ-019 sclkRise while in IDLE or in the same cycle csS = 1 SHALL be ignored.
REQ-020 On the sclkRise that completes bit 8 (cycle N), the byte and inverted dcS sampled at that cycle SHALL commit; rxValid high and rxData/rxIsCmd updated on cycle N+1; bit counter wraps to 0 and reception continues without cs toggling.
REQ-021 rxValid, rxData, rxIsCmd SHALL hold until the cycle rxValid && rxReady is sampled; rxValid then drops unless a new byte commits the same cycle.
REQ-022 Commit while rxValid = 1 and rxReady = 0: new byte SHALL be dropped, held byte unchanged, overrun set to 1 and held until reset.
REQ-023 Commit in the same cycle as rxValid && rxReady: new byte SHALL load, rxValid stays 1, overrun not set.
REQ-024 SHIFT -> IDLE with bit counter != 0: frameError SHALL pulse one cycle, partial byte discarded, counter cleared; with counter = 0 no pulse.
REQ-025 A held byte SHALL survive cs rising; only consumption or reset clears rxValid.

Reset
REQ-026 reset SHALL force state IDLE, shift register 0, bit counter 0, rxData 0x00, rxIsCmd 0, rxValid 0, overrun 0, frameError 0, byteCount 0, synchronizer flops to idle values (sclk 0, cs 1, mosi 0, dc 1).
REQ-027 reset asserted mid-byte SHALL discard the partial byte without frameError; after release, reception restarts only after csS is seen low.
REQ-028 reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-029 With macro SPI_RX_BYTE_COUNT_EN defined, byteCount SHALL clear on each csS falling edge and increment (wrapping 0xFFFF -> 0x0000) on every commit, including dropped (overrun) bytes.
REQ-030 Without SPI_RX_BYTE_COUNT_EN, the port SHALL remain present and tied to 0x0000, with no counter logic.

Verification
REQ-031 cs low, dc 0, shift 0x3C MSB first, rxReady 1 -> rxValid one cycle, rxData 0x3C, rxIsCmd 1.
REQ-032 cs low, dc 1, bytes 0xAA then 0x55 back-to-back, rxReady 0 until both sent -> rxData 0xAA, overrun 1, byteCount 2 (macro on) / 0 (off).
REQ-033 cs low, 5 bits of 0xFF then cs high -> frameError one-cycle pulse, rxValid stays 0, next full byte 0x81 received correctly.
REQ-034 Consume and commit same cycle (rxReady pulsed at commit) for 0x12 then 0x34 -> rxData 0x34, rxValid 1, overrun 0.
REQ-035 reset after 4 bits, release, cs cycled, byte 0xA5 sent -> rxData 0xA5, frameError never asserted.
